apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_master_pkg.sv | 29 ++
 rtl/apb_wait_timer.sv | 52 +++++
 rtl/apb_master_ctrl.sv | 168 ++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_pkg
// Brief    : Shared types and default constants for the APB master controller.
// Revision : 1.0 - initial release
// ============================================================================
package apb_master_pkg;

    localparam int c_DEF_ADDR_W  = 8;
    localparam int c_DEF_DATA_W  = 32;
    localparam int c_DEF_TIMEOUT = 15;
    // Widest data bus the response struct can carry.
    localparam int c_MAX_DATA_W  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [c_MAX_DATA_W-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_timer
// Brief    : Counts APB wait states; flags expiry when the count hits TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    generate
        if (TIMEOUT > 0) begin : g_timeout_on
            localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT);
            assign expired_o = (cnt_q == c_LIMIT);
        end else begin : g_timeout_off
            assign expired_o = 1'b0;
        end
    endgenerate

    // Saturate at the limit so the flag stays up until the next clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !expired_o) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_ctrl
// Brief    : Single-outstanding APB master with wait-state timeout.
//            Define APB_MASTER_PSTRB_EN to add APB4 write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
`ifdef APB_MASTER_PSTRB_EN
    input  logic [DATA_W/8-1:0] cmd_strb,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
`ifdef APB_MASTER_PSTRB_EN
    output logic [DATA_W/8-1:0] PSTRB,
`endif
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] paddr_q;
    logic [ADDR_W-1:0] paddr_d;
    logic              pwrite_q;
    logic              pwrite_d;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] pwdata_d;
    rsp_t              rsp_q;
    rsp_t              rsp_d;
`ifdef APB_MASTER_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb_q;
    logic [DATA_W/8-1:0] pstrb_d;
`endif

    logic w_accept;
    logic w_count_en;
    logic w_expired;
    logic w_unused_rdata;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk        (PCLK),
        .rst        (PRESET),
        .clear_i    (w_accept),
        .count_en_i (w_count_en),
        .expired_o  (w_expired)
    );

    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rsp_d      = rsp_q;
        w_accept   = 1'b0;
        w_count_en = 1'b0;
`ifdef APB_MASTER_PSTRB_EN
        pstrb_d    = pstrb_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    state_d  = SETUP;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
`ifdef APB_MASTER_PSTRB_EN
                    pstrb_d  = cmd_write ? cmd_strb : '0;
`endif
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                w_count_en = !PREADY;
                // A ready slave wins over a timeout landing on the same edge.
                if (PREADY) begin
                    state_d     = RESP;
                    rsp_d       = '0;
                    rsp_d.err   = PSLVERR;
                    if (!pwrite_q) begin
                        rsp_d.rdata[DATA_W-1:0] = PRDATA;
                    end
                end else if (w_expired) begin
                    state_d       = RESP;
                    rsp_d         = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rsp_q    <= '0;
`ifdef APB_MASTER_PSTRB_EN
            pstrb_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rsp_q    <= rsp_d;
`ifdef APB_MASTER_PSTRB_EN
            pstrb_q  <= pstrb_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
`ifdef APB_MASTER_PSTRB_EN
    assign PSTRB       = pstrb_q;
`endif
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    // Bits above DATA_W are always zero.
    assign w_unused_rdata = ^rsp_q.rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_ctrl
// Brief    : Self-checking bench for apb_master_ctrl (transaction-level model
//            plus directed scenarios with literal expectations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_ctrl;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
`ifdef APB_MASTER_PSTRB_EN
    logic [3:0]        cmd_strb = '0;
    logic [3:0]        PSTRB;
`endif
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              PREADY = 1'b0;
    logic              PSLVERR = 1'b0;

    apb_master_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
`ifdef APB_MASTER_PSTRB_EN
        .cmd_strb    (cmd_strb),
`endif
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
`ifdef APB_MASTER_PSTRB_EN
        .PSTRB       (PSTRB),
`endif
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef enum int {PH_IDLE, PH_SETUP, PH_ACCESS, PH_RESP} phase_e;
    phase_e      m_ph    = PH_IDLE;
    bit          m_on    = 1'b0;
    int          m_waits = 0;
    logic [7:0]  m_addr  = '0;
    logic        m_write = 1'b0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_strb  = '0;
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    logic        m_to    = 1'b0;

    always @(negedge PCLK) begin
        if (m_on) begin
            check("model cmd_ready", 64'(cmd_ready), 64'(m_ph == PH_IDLE));
            check("model PSEL",      64'(PSEL),      64'(m_ph == PH_SETUP || m_ph == PH_ACCESS));
            check("model PENABLE",   64'(PENABLE),   64'(m_ph == PH_ACCESS));
            check("model rsp_valid", 64'(rsp_valid), 64'(m_ph == PH_RESP));
            check("model PADDR",     64'(PADDR),     64'(m_addr));
            check("model PWRITE",    64'(PWRITE),    64'(m_write));
            check("model PWDATA",    64'(PWDATA),    64'(m_wdata));
            check("model rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
            check("model rsp_err",   64'(rsp_err),   64'(m_err));
            check("model rsp_timeout", 64'(rsp_timeout), 64'(m_to));
`ifdef APB_MASTER_PSTRB_EN
            check("model PSTRB",     64'(PSTRB),     64'(m_strb));
`endif
        end
        // Predict what the coming edge does from the inputs now applied.
        if (PRESET) begin
            m_on = 1'b1; m_ph = PH_IDLE; m_waits = 0;
            m_addr = '0; m_write = 1'b0; m_wdata = '0; m_strb = '0;
            m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
        end else if (m_on) begin
            case (m_ph)
                PH_IDLE: if (cmd_valid) begin
                    m_ph = PH_SETUP; m_addr = cmd_addr; m_write = cmd_write;
                    m_wdata = cmd_write ? cmd_wdata : 32'h0;
`ifdef APB_MASTER_PSTRB_EN
                    m_strb = cmd_write ? cmd_strb : 4'h0;
`endif
                end
                PH_SETUP: begin m_ph = PH_ACCESS; m_waits = 0; end
                PH_ACCESS: begin
                    if (PREADY) begin
                        m_ph = PH_RESP; m_err = PSLVERR; m_to = 1'b0;
                        m_rdata = m_write ? 32'h0 : PRDATA;
                    end else if (TIMEOUT > 0 && m_waits == TIMEOUT) begin
                        m_ph = PH_RESP; m_err = 1'b1; m_to = 1'b1; m_rdata = 32'h0;
                    end else begin
                        m_waits++;
                    end
                end
                PH_RESP: if (rsp_ready) m_ph = PH_IDLE;
                default: m_ph = PH_IDLE;
            endcase
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] g_rdata;
    logic        g_err;
    logic        g_to;

    // waits: ACCESS cycles with PREADY low before it rises (large = never).
    // exp_lat: rsp_valid first seen this many cycles after the accept cycle.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int waits, input bit slverr,
                        input logic [31:0] rd, input int hold, input int exp_lat);
        int n;
        int lat;
        n = -1;
        lat = -1;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
`ifdef APB_MASTER_PSTRB_EN
        cmd_strb = strb;
`endif
        PRDATA = rd; PSLVERR = slverr; PREADY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (cmd_ready) begin n = cyc; break; end
            @(posedge PCLK); #1;
        end
        if (n < 0) begin
            check("accept timeout", 64'(0), 64'(1));
            cmd_valid = 1'b0;
            return;
        end
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 32'h0BAD0BAD; cmd_write = ~wr;
        PREADY = (waits == 0);
        @(negedge PCLK);
        check("setup PSEL/PENABLE", 64'({PSEL, PENABLE}), 64'(2'b10));
        check("setup PADDR", 64'(PADDR), 64'(addr));
`ifdef APB_MASTER_PSTRB_EN
        check("setup PSTRB", 64'(PSTRB), 64'(wr ? strb : 4'h0));
`endif
        for (int k = 0; k < 40; k++) begin
            @(posedge PCLK); #1;
            PREADY = (k >= waits);
            @(negedge PCLK);
            if (k == 0) check("access PSEL/PENABLE", 64'({PSEL, PENABLE}), 64'(2'b11));
            if (rsp_valid) begin lat = cyc - n; break; end
        end
        check("rsp latency", 64'(lat), 64'(exp_lat));
        g_rdata = rsp_rdata; g_err = rsp_err; g_to = rsp_timeout;
        for (int h = 0; h < hold; h++) begin
            @(posedge PCLK); #1;
            PREADY = 1'b0; rsp_ready = 1'b0;
            cmd_valid = 1'b1; cmd_addr = 8'h77; cmd_write = 1'b1;
            @(negedge PCLK);
            check("hold cmd_ready", 64'(cmd_ready), 64'(0));
            check("hold rsp stable", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}),
                  64'({1'b1, g_rdata, g_err, g_to}));
        end
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; PREADY = 1'b0; rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        @(negedge PCLK);
        check("back to idle", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("reset cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset APB ctrl", 64'({PSEL, PENABLE, PWRITE}), 64'(0));
        check("reset PADDR/PWDATA", 64'({PADDR, PWDATA}), 64'(0));
        check("reset rsp", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 64'(0));

        // Zero-wait write.
        xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h12345678, 0, 3);
        check("write rsp_err", 64'(g_err), 64'(0));
        check("write rsp_rdata", 64'(g_rdata), 64'(0));

        // Read with three wait states.
        xfer(1'b0, 8'h20, 32'h11111111, 4'hF, 3, 1'b0, 32'hCAFEF00D, 0, 6);
        check("read rsp_rdata", 64'(g_rdata), 64'(32'hCAFEF00D));
        check("read rsp_err", 64'(g_err), 64'(0));

        // Read that never completes: aborted after TIMEOUT waits.
        xfer(1'b0, 8'h30, 32'h0, 4'hF, 1000, 1'b0, 32'h55AA55AA, 0, TIMEOUT + 3);
        check("timeout rsp", 64'({g_rdata, g_err, g_to}), 64'({32'h0, 1'b1, 1'b1}));

        // Slave error on write, response held back by the consumer.
        xfer(1'b1, 8'h44, 32'hA5A5A5A5, 4'hF, 0, 1'b1, 32'h0, 4, 3);
        check("slverr rsp", 64'({g_err, g_to}), 64'({1'b1, 1'b0}));

        // Reset pulsed during ACCESS of a write.
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h5C; cmd_wdata = 32'h01020304;
        PREADY = 1'b0; PSLVERR = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge PCLK);
            if (PENABLE) seen = 1;
            @(posedge PCLK); #1;
            cmd_valid = 1'b0;
        end
        check("reach ACCESS", 64'(seen), 64'(1));
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        check("post-reset PSEL/PENABLE/rsp_valid", 64'({PSEL, PENABLE, rsp_valid}), 64'(0));
        check("post-reset cmd_ready", 64'(cmd_ready), 64'(1));
        check("post-reset PADDR", 64'(PADDR), 64'(0));

        xfer(1'b0, 8'h66, 32'h0, 4'hF, 1, 1'b0, 32'h89ABCDEF, 0, 4);
        check("post-reset read rdata", 64'(g_rdata), 64'(32'h89ABCDEF));

`ifdef APB_MASTER_PSTRB_EN
        xfer(1'b1, 8'h70, 32'hFEEDFACE, 4'b0101, 0, 1'b0, 32'h0, 0, 3);
        check("strb write PSTRB held", 64'(PSTRB), 64'(4'b0101));
        xfer(1'b0, 8'h74, 32'h0, 4'b1111, 0, 1'b0, 32'h13579BDF, 0, 3);
        check("strb read PSTRB", 64'(PSTRB), 64'(4'b0000));
`endif

        repeat (2) @(posedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
